// File: rtl/ctrl_fsm_seq.sv
// Multi-cycle sequencing control unit: accepts instruction words over valid/ready and
// steps them through DECODE/EXEC/WB, waiting on alu_done for multi-cycle shifts.
module ctrl_fsm_seq #(
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT     = 16,
    parameter int MULTI_SHIFT = 1,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [4+2*ADDR_W-1:0] instr,
    input  logic                alu_done,
    input  logic                err_clr,
    output logic [3:0]          alu_op,
    output logic                alu_src,
    output logic                alu_start,
    output logic [ADDR_W-1:0]   rd_addr_a,
    output logic [ADDR_W-1:0]   rd_addr_b,
    output logic [ADDR_W-1:0]   imm,
    output logic                reg_write,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                busy,
    output logic                timeout_err,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int IW = 4 + 2*ADDR_W;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    state_t          state, state_n;
    logic            wr_int, multi;
    logic [TW-1:0]   cyc;
    logic            accept, timeout, retire;
    logic [3:0]      opc;
    logic [ADDR_W-1:0] fa, fb;

    assign opc         = instr[IW-1 -: 4];
    assign fa          = instr[2*ADDR_W-1 -: ADDR_W];
    assign fb          = instr[ADDR_W-1:0];
    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign accept      = instr_valid & instr_ready;

    always_comb begin
        state_n = state;
        timeout = 1'b0;
        retire  = 1'b0;
        case (state)
            IDLE:   if (accept) state_n = DECODE;
            DECODE: state_n = EXEC;
            EXEC: begin
                if (!multi) begin
                    state_n = wr_int ? WB : IDLE;
                    retire  = !wr_int;
                end else if (alu_done) begin
                    state_n = WB;
                end else if (cyc == TW'(TIMEOUT)) begin
                    // abandoned op: no write-back and not retired
                    state_n = IDLE;
                    timeout = 1'b1;
                end
            end
            WB: begin
                state_n = IDLE;
                retire  = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            alu_op      <= '0;
            alu_src     <= 1'b0;
            alu_start   <= 1'b0;
            rd_addr_a   <= '0;
            rd_addr_b   <= '0;
            imm         <= '0;
            reg_write   <= 1'b0;
            wr_addr     <= '0;
            timeout_err <= 1'b0;
            instr_count <= '0;
            wr_int      <= 1'b0;
            multi       <= 1'b0;
            cyc         <= '0;
        end else begin
            state     <= state_n;
            alu_start <= (state == DECODE);
            reg_write <= (state == EXEC) && (state_n == WB);
            // fields are captured at accept so they are already visible during DECODE
            if (accept) begin
                alu_op    <= opc;
                alu_src   <= (opc == 4'h1) || (opc >= 4'hC);
                rd_addr_a <= fa;
                rd_addr_b <= fb;
                imm       <= fb;
                wr_int    <= !((opc == 4'h0) || (opc == 4'h2));
                multi     <= (MULTI_SHIFT != 0) && (opc >= 4'hE);
            end
            if ((state == EXEC) && (state_n == WB))
                wr_addr <= rd_addr_a;
            if (state == DECODE)
                cyc <= TW'(1);
            else if ((state == EXEC) && multi && !alu_done && (cyc != TW'(TIMEOUT)))
                cyc <= cyc + 1'b1;
            if (timeout)
                timeout_err <= 1'b1;
            else if (err_clr)
                timeout_err <= 1'b0;
            if (retire)
                instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm_seq.sv
// Directed bench for ctrl_fsm_seq: three instances (default, single-cycle shifts, 4-bit
// counter) driven in turn; expected write-backs are queued at issue and popped on reg_write.
module tb_ctrl_fsm_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv[3], dn[3], ec[3];
    logic [11:0] ins[3];
    logic        rdy[3], asrc[3], ast[3], rw[3], bsy[3], terr[3];
    logic [3:0]  aop[3], ra[3], rb[3], im[3], wa[3];
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int cnt_m[3];
    int err_m[3];
    logic [3:0] wq[$];

    ctrl_fsm_seq #(.ADDR_W(4), .TIMEOUT(16), .MULTI_SHIFT(1), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .instr_valid(iv[0]), .instr_ready(rdy[0]), .instr(ins[0]),
        .alu_done(dn[0]), .err_clr(ec[0]), .alu_op(aop[0]), .alu_src(asrc[0]),
        .alu_start(ast[0]), .rd_addr_a(ra[0]), .rd_addr_b(rb[0]), .imm(im[0]),
        .reg_write(rw[0]), .wr_addr(wa[0]), .busy(bsy[0]), .timeout_err(terr[0]),
        .instr_count(cnt0));

    ctrl_fsm_seq #(.ADDR_W(4), .TIMEOUT(16), .MULTI_SHIFT(0), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .instr_valid(iv[1]), .instr_ready(rdy[1]), .instr(ins[1]),
        .alu_done(dn[1]), .err_clr(ec[1]), .alu_op(aop[1]), .alu_src(asrc[1]),
        .alu_start(ast[1]), .rd_addr_a(ra[1]), .rd_addr_b(rb[1]), .imm(im[1]),
        .reg_write(rw[1]), .wr_addr(wa[1]), .busy(bsy[1]), .timeout_err(terr[1]),
        .instr_count(cnt1));

    ctrl_fsm_seq #(.ADDR_W(4), .TIMEOUT(16), .MULTI_SHIFT(1), .CNT_W(4)) u2 (
        .clk(clk), .rst(rst), .instr_valid(iv[2]), .instr_ready(rdy[2]), .instr(ins[2]),
        .alu_done(dn[2]), .err_clr(ec[2]), .alu_op(aop[2]), .alu_src(asrc[2]),
        .alu_start(ast[2]), .rd_addr_a(ra[2]), .rd_addr_b(rb[2]), .imm(im[2]),
        .reg_write(rw[2]), .wr_addr(wa[2]), .busy(bsy[2]), .timeout_err(terr[2]),
        .instr_count(cnt2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt_of(input int d);
        if (d == 2) return {12'h000, cnt2};
        if (d == 1) return cnt1;
        return cnt0;
    endfunction

    function automatic int cnt_exp(input int d);
        return (d == 2) ? (cnt_m[d] % 16) : (cnt_m[d] % 65536);
    endfunction

    // Issue one instruction to instance d; done_at = EXEC cycle (1-based) carrying alu_done, 0 = never.
    task automatic run(input int d, input logic [11:0] w, input int done_at);
        logic [3:0] op;
        int wi, mul, e, lat, c, nwr, tmo;
        op  = w[11:8];
        wi  = (op != 4'h0 && op != 4'h2) ? 1 : 0;
        mul = (d != 1 && op >= 4'hE) ? 1 : 0;
        tmo = 0;
        if (mul == 0) e = 1;
        else if (done_at >= 1 && done_at <= 16) e = done_at;
        else begin e = 16; wi = 0; tmo = 1; end
        lat = 2 + e + wi;
        if (wi != 0) wq.push_back(w[7:4]);
        for (int i = 0; i < 50 && !rdy[d]; i++) @(negedge clk);
        chk("ready_before_issue", rdy[d], 1'b1);
        iv[d] = 1'b1; ins[d] = w;
        @(negedge clk);
        iv[d] = 1'b0; c = 1;
        chk("decode_alu_op", aop[d], op);
        chk("decode_alu_src", asrc[d], (op == 4'h1 || op >= 4'hC) ? 1'b1 : 1'b0);
        chk("decode_rd_a", ra[d], w[7:4]);
        chk("decode_rd_b", rb[d], w[3:0]);
        chk("decode_imm", im[d], w[3:0]);
        chk("decode_busy", bsy[d], 1'b1);
        nwr = 0;
        while (!rdy[d] && c < 60) begin
            dn[d] = (done_at != 0 && c == done_at + 1);
            @(negedge clk);
            c++;
            if (c == 2) chk("alu_start", ast[d], 1'b1);
            if (c == 3) chk("alu_start_pulse", ast[d], 1'b0);
            if (rw[d]) begin
                nwr++;
                if (wq.size() > 0) chk("wr_addr", wa[d], wq.pop_front());
            end
        end
        dn[d] = 1'b0;
        chk("ready_latency", c, lat);
        chk("reg_write_pulses", nwr, wi);
        if (tmo != 0) err_m[d] = 1; else cnt_m[d]++;
        chk("instr_count", cnt_of(d), cnt_exp(d));
        chk("timeout_err", terr[d], err_m[d][0]);
    endtask

    initial begin
        int h;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; dn[i] = 0; ec[i] = 0; ins[i] = '0; cnt_m[i] = 0; err_m[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_busy", bsy[0], 1'b0);
        chk("rst_alu_op", aop[0], 4'h0);
        chk("rst_reg_write", rw[0], 1'b0);
        chk("rst_count", cnt0, 16'h0);
        chk("rst_terr", terr[0], 1'b0);

        run(0, 12'hA35, 0);   // ADD
        run(0, 12'hC27, 1);   // ADDI, alu_done ignored on a single-cycle op
        run(0, 12'h240, 0);   // READ
        run(0, 12'hE13, 5);   // SLL, done on 5th EXEC cycle
        run(1, 12'hE13, 1);   // SLL on single-cycle-shift instance
        run(0, 12'hF13, 0);   // SRL timeout

        @(negedge clk); ec[0] = 1'b1;
        @(negedge clk); ec[0] = 1'b0; err_m[0] = 0;
        chk("err_clr", terr[0], 1'b0);

        run(0, 12'hF24, 16);  // done on the timeout cycle wins

        // valid held high: NOP turnaround is 3 cycles, so 9 cycles hold 3 accepts
        h = 0;
        iv[0] = 1'b1; ins[0] = 12'h000;
        for (int i = 0; i < 9; i++) begin
            if (rdy[0]) h++;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        cnt_m[0] += 3;
        chk("bp_accepts", h, 3);
        chk("bp_count", cnt0, 16'(cnt_exp(0)));

        for (int i = 0; i < 17; i++) run(2, 12'h000, 0);
        chk("wrap_count", cnt2, 4'h1);

        // async reset in the middle of a multi-cycle EXEC
        iv[0] = 1'b1; ins[0] = 12'hF13;
        @(negedge clk); iv[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", bsy[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("arst_busy", bsy[0], 1'b0);
        chk("arst_alu_op", aop[0], 4'h0);
        chk("arst_alu_src", asrc[0], 1'b0);
        chk("arst_rd_a", ra[0], 4'h0);
        chk("arst_imm", im[0], 4'h0);
        chk("arst_count", cnt0, 16'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", rdy[0], 1'b1);
        chk("post_rst_reg_write", rw[0], 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm_seq.md
Name: ctrl_fsm_seq

Overview:
- Multi-cycle sequencing control unit for the simple microprocessor datapath; next generation of the single-cycle registered opcode decoder.
- Accepts instructions over a valid/ready handshake and splits fields (opcode, operand A, operand B/immediate) with parametrised widths.
- Steps each instruction through DECODE / EXEC / WB.
- Waits on an ALU completion handshake for multi-cycle shift ops, with a timeout, a sticky error flag and a retired-instruction counter.

Parameters:
- ADDR_W, 4, width of the register-address / immediate fields.
- TIMEOUT, 16, max EXEC cycles waiting for alu_done on multi-cycle ops (≥1).
- MULTI_SHIFT, 1, 1 = SLL/SRL are multi-cycle (wait alu_done); 0 = all ops single-cycle.
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction word valid.
- instr_ready  out  1  unit can accept an instruction.
- instr  in  4+2*ADDR_W  {opcode[3:0], fld_a[ADDR_W-1:0], fld_b[ADDR_W-1:0]}.
- alu_done  in  1  ALU completion for multi-cycle op.
- err_clr  in  1  clears timeout_err.
- alu_op  out  4  ALU operation code.
- alu_src  out  1  1 = ALU input2 from imm, 0 = from register.
- alu_start  out  1  one-cycle pulse, first EXEC cycle.
- rd_addr_a  out  ADDR_W  read address A (also the destination).
- rd_addr_b  out  ADDR_W  read address B.
- imm  out  ADDR_W  immediate (= fld_b).
- reg_write  out  1  one-cycle write-enable pulse in WB.
- wr_addr  out  ADDR_W  write address, valid while reg_write=1.
- busy  out  1  state != IDLE.
- timeout_err  out  1  sticky EXEC timeout flag.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset: async, immediate, from any state including mid-EXEC.
  - State → IDLE.
  - instr_ready=1 after reset release.
  - alu_op=0, alu_src=0, alu_start=0, reg_write=0, busy=0, timeout_err=0, instr_count=0.
  - All address/imm outputs = 0.
- All outputs are registered except instr_ready and busy, which are decoded from the state register.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - Accept on instr_valid & instr_ready at a rising edge: latch the fields, go to DECODE.
  - No accept in any other state; instr_ready=0 there.
- DECODE:
  - Register alu_op=opcode. rd_addr_a=fld_a, rd_addr_b=fld_b, imm=fld_b.
  - alu_src=1 for opcodes 0x1, 0xC–0xF; 0 otherwise.
  - Write-intent=1 for opcodes 0x1, 0x3–0xF; 0 for 0x0 (NOP) and 0x2 (READ).
  - Multi-cycle = MULTI_SHIFT & (opcode==0xE or 0xF).
  - Next state: EXEC. alu_start=1 during the first EXEC cycle only.
- EXEC, single-cycle op: one cycle, then WB if write-intent, else IDLE.
- EXEC, multi-cycle op:
  - Cycle counter starts at 1 on the first EXEC cycle.
  - alu_done=1 → WB.
  - Else if counter==TIMEOUT → set timeout_err, go to IDLE, no write, not counted as retired.
  - Else counter+1.
  - alu_done and counter==TIMEOUT in the same cycle: done wins, no error.
- alu_done is ignored outside multi-cycle EXEC.
- WB:
  - reg_write=1 for exactly one cycle; wr_addr=fld_a.
  - instr_count+1.
  - Next state: IDLE.
- NOP/READ: instr_count+1 on the EXEC→IDLE transition.
- Latency (single-cycle op accepted at edge k):
  - DECODE in cycle k+1, EXEC in k+2, WB in k+3.
  - instr_ready=1 again in k+4 (write ops) or k+3 (NOP/READ).
- alu_op, alu_src, addresses and imm hold their values from DECODE until the next DECODE.
- timeout_err is cleared by err_clr=1 at an edge. If a set and err_clr coincide, the set wins.
- instr_count wraps from 2^CNT_W−1 to 0.

Test Plan:
- ADD: reset, then instr={0xA,3,5}, valid one cycle at edge k → k+1: alu_op=0xA, alu_src=0; k+2: alu_start=1; k+3: reg_write=1, wr_addr=3; k+4: instr_ready=1; instr_count=1.
- ADDI and READ: {0xC,2,7} → alu_src=1, imm=7, reg_write pulse with wr_addr=2. Then {0x2,4,0} → no reg_write; instr_ready back after 3 cycles; instr_count=2.
- SLL with done: {0xE,1,3}, MULTI_SHIFT=1, alu_done asserted on the 5th EXEC cycle → WB on the next cycle, reg_write=1, no error. Repeat with MULTI_SHIFT=0 → single-cycle path, alu_done ignored.
- Timeout: SRL with alu_done held 0, TIMEOUT=16 → after 16 EXEC cycles timeout_err=1, state IDLE, no reg_write, instr_count unchanged; err_clr → timeout_err=0. Done on the 16th cycle → no error.
- Backpressure and reset: instr_valid held high continuously → exactly one accept per instr_ready window. Assert rst mid-EXEC of a SRL → all outputs at reset values immediately, instr_ready=1 after release.
- Wrap: CNT_W=4, retire 17 NOPs → instr_count=1.
